// File: rtl/cdb_writeback_ctrl_if.sv
// cdb_writeback_ctrl_if
//   Bundles the result-request, issue-rename, status-lookup, CDB broadcast and
//   register-file write-port signals of the CDB writeback controller.
//   Parameters: N_REQ requesters, TAG_W tag width, DATA_W data width.
//   master : functional units / issue stage / register file side
//   slave  : cdb_writeback_ctrl
interface cdb_writeback_ctrl_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned REG_W = 4;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*REG_W-1:0]  req_dest;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_grant;

    logic                    issue_valid;
    logic [REG_W-1:0]        issue_dest;
    logic [TAG_W-1:0]        issue_tag;

    logic [REG_W-1:0]        look_reg;
    logic                    look_busy;
    logic [TAG_W-1:0]        look_tag;

    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;

    logic                    store;
    logic [REG_W-1:0]        reg_a;
    logic [DATA_W-1:0]       data_in;

    modport master (
        output req_valid, req_tag, req_dest, req_data,
        output issue_valid, issue_dest, issue_tag,
        output look_reg,
        input  req_grant, look_busy, look_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  store, reg_a, data_in
    );

    modport slave (
        input  req_valid, req_tag, req_dest, req_data,
        input  issue_valid, issue_dest, issue_tag,
        input  look_reg,
        output req_grant, look_busy, look_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output store, reg_a, data_in
    );
endinterface

// File: rtl/cdb_writeback_ctrl.sv
// cdb_writeback_ctrl
//   Common-data-bus scheduler and register-status (Qi) controller.
//   Picks one functional-unit result per cycle, broadcasts it on the CDB one cycle
//   later, and writes the register file only if the broadcast tag is still the
//   latest producer of the destination register.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   i_flush  synchronous squash: clears Qi, blocks grants, drops next broadcast
//   io_bus   request / issue / lookup / CDB / register-file write signals
//            (req_grant, look_busy, look_tag are combinational; rest registered)
// Configuration macro:
//   CDB_ROUND_ROBIN_EN  round-robin arbitration starting at rr_ptr;
//                       undefined -> fixed priority, lowest index wins.
module cdb_writeback_ctrl #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_flush,
    cdb_writeback_ctrl_if.slave  io_bus
);
    localparam int unsigned NREG  = 16;
    localparam int unsigned REG_W = 4;
    localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TAG_W-1:0]  r_qi [NREG];
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic              r_store;
    logic [REG_W-1:0]  r_reg_a;
    logic [DATA_W-1:0] r_data_in;

    logic              w_any;
    logic [SEL_W-1:0]  w_win;
    logic [N_REQ-1:0]  w_grant;
    logic [TAG_W-1:0]  w_sel_tag;
    logic [REG_W-1:0]  w_sel_dest;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_match;

`ifdef CDB_ROUND_ROBIN_EN
    logic [SEL_W-1:0]  r_rr_ptr;
`endif

    // Arbitration: optional first pass from rr_ptr upward, then lowest valid index.
    always_comb begin : arb
        w_any = 1'b0;
        w_win = '0;
`ifdef CDB_ROUND_ROBIN_EN
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && io_bus.req_valid[j] && (SEL_W'(j) >= r_rr_ptr)) begin
                w_any = 1'b1;
                w_win = SEL_W'(j);
            end
        end
`endif
        for (int j = 0; j < N_REQ; j++) begin
            if (!w_any && io_bus.req_valid[j]) begin
                w_any = 1'b1;
                w_win = SEL_W'(j);
            end
        end
        if (i_reset || i_flush) begin
            w_any = 1'b0;
        end
    end

    // Winner payload select and one-hot grant.
    always_comb begin : sel
        w_grant    = '0;
        w_sel_tag  = '0;
        w_sel_dest = '0;
        w_sel_data = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (SEL_W'(j) == w_win) begin
                w_sel_tag  = io_bus.req_tag[j*TAG_W +: TAG_W];
                w_sel_dest = io_bus.req_dest[j*REG_W +: REG_W];
                w_sel_data = io_bus.req_data[j*DATA_W +: DATA_W];
            end
        end
        if (w_any) begin
            w_grant = N_REQ'(1) << w_win;
        end
    end

    // Write filter uses the pre-update Qi value.
    assign w_match = (r_qi[w_sel_dest] == w_sel_tag);

    // Broadcast, write port and Qi table; issue is applied last so it wins on a collision.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_store     <= 1'b0;
            r_reg_a     <= '0;
            r_data_in   <= '0;
            for (int r = 0; r < NREG; r++) begin
                r_qi[r] <= '0;
            end
        end else if (i_flush) begin
            r_cdb_valid <= 1'b0;
            r_store     <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                r_qi[r] <= '0;
            end
        end else begin
            r_cdb_valid <= w_any;
            r_store     <= w_any && w_match;
            if (w_any) begin
                r_cdb_tag  <= w_sel_tag;
                r_cdb_data <= w_sel_data;
                r_reg_a    <= w_sel_dest;
                r_data_in  <= w_sel_data;
                if (w_match) begin
                    r_qi[w_sel_dest] <= '0;
                end
            end
            if (io_bus.issue_valid) begin
                r_qi[io_bus.issue_dest] <= io_bus.issue_tag;
            end
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    // Pointer moves past the winner after each grant; held when idle or flushed.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_win == SEL_W'(N_REQ - 1)) ? '0 : w_win + SEL_W'(1);
        end
    end
`endif

    assign io_bus.req_grant = w_grant;
    assign io_bus.look_tag  = r_qi[io_bus.look_reg];
    assign io_bus.look_busy = |r_qi[io_bus.look_reg];
    assign io_bus.cdb_valid = r_cdb_valid;
    assign io_bus.cdb_tag   = r_cdb_tag;
    assign io_bus.cdb_data  = r_cdb_data;
    assign io_bus.store     = r_store;
    assign io_bus.reg_a     = r_reg_a;
    assign io_bus.data_in   = r_data_in;

    // Tag 0 means "no producer" and must never be issued or broadcast.
    a_issue_tag_nz: assert property (@(posedge i_clock) disable iff (i_reset)
        io_bus.issue_valid |-> (io_bus.issue_tag != '0));
    a_grant_tag_nz: assert property (@(posedge i_clock) disable iff (i_reset)
        w_any |-> (w_sel_tag != '0));
    a_grant_onehot: assert property (@(posedge i_clock) $onehot0(w_grant));
endmodule

// File: tb/tb_cdb_writeback_ctrl.sv
// Table-driven bench for cdb_writeback_ctrl plus a hand-written reset-after-grant sequence.
module tb_cdb_writeback_ctrl;
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_writeback_ctrl_if #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

    cdb_writeback_ctrl #(.N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_flush (flush),
        .io_bus  (bus)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [3:0]  id;
        logic [2:0]  it;
        logic [2:0]  rv;
        logic [8:0]  rt;
        logic [11:0] rd;
        logic [47:0] rdat;
        logic [3:0]  lk;
        logic [2:0]  eg;
        logic        eb;
        logic [2:0]  elt;
        logic        ecv;
        logic [2:0]  ect;
        logic [15:0] ecd;
        logic        est;
        logic [3:0]  era;
        logic [15:0] edin;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [8:0]  ALL_T = {3'd7, 3'd6, 3'd5};
    localparam logic [11:0] ALL_D = {4'd4, 4'd3, 4'd1};
    localparam logic [47:0] ALL_X = {16'h4444, 16'h3333, 16'h1111};

    function automatic void add(
        input logic fl, input logic iv, input logic [3:0] id, input logic [2:0] it,
        input logic [2:0] rv, input logic [8:0] rt, input logic [11:0] rd,
        input logic [47:0] rdat, input logic [3:0] lk,
        input logic [2:0] eg, input logic eb, input logic [2:0] elt,
        input logic ecv, input logic [2:0] ect, input logic [15:0] ecd,
        input logic est, input logic [3:0] era, input logic [15:0] edin);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.it = it; v.rv = rv; v.rt = rt; v.rd = rd;
        v.rdat = rdat; v.lk = lk; v.eg = eg; v.eb = eb; v.elt = elt; v.ecv = ecv;
        v.ect = ect; v.ecd = ecd; v.est = est; v.era = era; v.edin = edin;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush           = 1'b0;
        bus.req_valid   = '0;
        bus.req_tag     = '0;
        bus.req_dest    = '0;
        bus.req_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dest  = '0;
        bus.issue_tag   = '0;
        bus.look_reg    = '0;
    endtask

    initial begin
        vec_t v;
        // idle-vector shorthand fields are all zero except lookup and expectations
        // test 1: rename r5<-3, broadcast matching tag, status clears
        add(0,1,4'd5,3'd3, 3'b000, 9'd0, 12'd0, 48'd0, 4'd5,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b001, {3'd0,3'd0,3'd3}, {4'd0,4'd0,4'd5}, {16'h0,16'h0,16'h00AA}, 4'd5,
            3'b001,1,3'd3, 1,3'd3,16'h00AA, 1,4'd5,16'h00AA);
        add(0,0,4'd0,3'd0, 3'b000, 9'd0, 12'd0, 48'd0, 4'd5,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        // test 2: stale tag after re-rename
        add(0,1,4'd2,3'd1, 3'b000, 9'd0, 12'd0, 48'd0, 4'd2,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,1,4'd2,3'd4, 3'b000, 9'd0, 12'd0, 48'd0, 4'd2,  3'b000,1,3'd1, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b010, {3'd0,3'd1,3'd0}, {4'd0,4'd2,4'd0}, {16'h0,16'h1234,16'h0}, 4'd2,
            3'b010,1,3'd4, 1,3'd1,16'h1234, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b000, 9'd0, 12'd0, 48'd0, 4'd2,  3'b000,1,3'd4, 0,3'd0,16'h0, 0,4'd0,16'h0);
        // test 4: same-cycle issue and matching writeback
        add(0,1,4'd7,3'd2, 3'b000, 9'd0, 12'd0, 48'd0, 4'd7,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,1,4'd7,3'd6, 3'b100, {3'd2,3'd0,3'd0}, {4'd7,4'd0,4'd0}, {16'h0F0F,16'h0,16'h0}, 4'd7,
            3'b100,1,3'd2, 1,3'd2,16'h0F0F, 1,4'd7,16'h0F0F);
        add(0,0,4'd0,3'd0, 3'b000, 9'd0, 12'd0, 48'd0, 4'd7,  3'b000,1,3'd6, 0,3'd0,16'h0, 0,4'd0,16'h0);
        // test 3: all requesters valid for three cycles
        add(0,1,4'd1,3'd5, 3'b000, 9'd0, 12'd0, 48'd0, 4'd1,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,1,4'd3,3'd6, 3'b000, 9'd0, 12'd0, 48'd0, 4'd1,  3'b000,1,3'd5, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,1,4'd4,3'd7, 3'b000, 9'd0, 12'd0, 48'd0, 4'd3,  3'b000,1,3'd6, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b111, ALL_T, ALL_D, ALL_X, 4'd4,  3'b001,1,3'd7, 1,3'd5,16'h1111, 1,4'd1,16'h1111);
`ifdef CDB_ROUND_ROBIN_EN
        add(0,0,4'd0,3'd0, 3'b111, ALL_T, ALL_D, ALL_X, 4'd1,  3'b010,0,3'd0, 1,3'd6,16'h3333, 1,4'd3,16'h3333);
        add(0,0,4'd0,3'd0, 3'b111, ALL_T, ALL_D, ALL_X, 4'd3,  3'b100,0,3'd0, 1,3'd7,16'h4444, 1,4'd4,16'h4444);
`else
        add(0,0,4'd0,3'd0, 3'b111, ALL_T, ALL_D, ALL_X, 4'd1,  3'b001,0,3'd0, 1,3'd5,16'h1111, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b111, ALL_T, ALL_D, ALL_X, 4'd3,  3'b001,1,3'd6, 1,3'd5,16'h1111, 0,4'd0,16'h0);
`endif
        // test 5: flush blocks grant, clears Qi, kills next broadcast
        add(0,1,4'd1,3'd5, 3'b000, 9'd0, 12'd0, 48'd0, 4'd1,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(1,0,4'd0,3'd0, 3'b001, {3'd0,3'd0,3'd5}, {4'd0,4'd0,4'd1}, {16'h0,16'h0,16'h5555}, 4'd1,
            3'b000,1,3'd5, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b000, 9'd0, 12'd0, 48'd0, 4'd1,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b000, 9'd0, 12'd0, 48'd0, 4'd4,  3'b000,0,3'd0, 0,3'd0,16'h0, 0,4'd0,16'h0);
        add(0,0,4'd0,3'd0, 3'b001, {3'd0,3'd0,3'd5}, {4'd0,4'd0,4'd1}, {16'h0,16'h0,16'h5555}, 4'd1,
            3'b001,0,3'd0, 1,3'd5,16'h5555, 0,4'd0,16'h0);

        // reset with a request pending: no grant, all outputs cleared
        drive_idle();
        rst = 1'b1;
        bus.req_valid = 3'b001;
        bus.req_tag   = 9'd1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst grant", 64'(bus.req_grant), 64'd0);
        chk("rst cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst store", 64'(bus.store), 64'd0);
        chk("rst cdb_tag", 64'(bus.cdb_tag), 64'd0);
        chk("rst cdb_data", 64'(bus.cdb_data), 64'd0);
        chk("rst reg_a", 64'(bus.reg_a), 64'd0);
        chk("rst data_in", 64'(bus.data_in), 64'd0);
        for (int r = 0; r < 16; r++) begin
            bus.look_reg = 4'(r);
            #0.1;
            chk($sformatf("rst busy r%0d", r), 64'(bus.look_busy), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            flush           = v.fl;
            bus.issue_valid = v.iv;
            bus.issue_dest  = v.id;
            bus.issue_tag   = v.it;
            bus.req_valid   = v.rv;
            bus.req_tag     = v.rt;
            bus.req_dest    = v.rd;
            bus.req_data    = v.rdat;
            bus.look_reg    = v.lk;
            #1;
            chk($sformatf("v%0d grant", i), 64'(bus.req_grant), 64'(v.eg));
            chk($sformatf("v%0d look_busy", i), 64'(bus.look_busy), 64'(v.eb));
            chk($sformatf("v%0d look_tag", i), 64'(bus.look_tag), 64'(v.elt));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cdb_valid", i), 64'(bus.cdb_valid), 64'(v.ecv));
            chk($sformatf("v%0d store", i), 64'(bus.store), 64'(v.est));
            if (v.ecv) begin
                chk($sformatf("v%0d cdb_tag", i), 64'(bus.cdb_tag), 64'(v.ect));
                chk($sformatf("v%0d cdb_data", i), 64'(bus.cdb_data), 64'(v.ecd));
            end
            if (v.est) begin
                chk($sformatf("v%0d reg_a", i), 64'(bus.reg_a), 64'(v.era));
                chk($sformatf("v%0d data_in", i), 64'(bus.data_in), 64'(v.edin));
            end
        end

        // test 6: reset in the cycle after a grant drops the broadcast and clears Qi
        @(negedge clk);
        drive_idle();
        bus.issue_valid = 1'b1;
        bus.issue_dest  = 4'd9;
        bus.issue_tag   = 3'd3;
        @(negedge clk);
        bus.issue_dest  = 4'd10;
        bus.issue_tag   = 3'd4;
        @(negedge clk);
        drive_idle();
        bus.req_valid = 3'b001;
        bus.req_tag   = {3'd0, 3'd0, 3'd3};
        bus.req_dest  = {4'd0, 4'd0, 4'd9};
        bus.req_data  = {16'h0, 16'h0, 16'hBEEF};
        bus.look_reg  = 4'd10;
        #1;
        chk("t6 grant", 64'(bus.req_grant), 64'b001);
        chk("t6 busy r10", 64'(bus.look_busy), 64'd1);
        @(posedge clk);
        #1;
        chk("t6 cdb_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t6 store", 64'(bus.store), 64'd1);
        chk("t6 reg_a", 64'(bus.reg_a), 64'd9);
        chk("t6 data_in", 64'(bus.data_in), 64'hBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6 rst grant", 64'(bus.req_grant), 64'd0);
        @(posedge clk);
        #1;
        chk("t6 rst cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("t6 rst store", 64'(bus.store), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        for (int r = 0; r < 16; r++) begin
            bus.look_reg = 4'(r);
            #0.1;
            chk($sformatf("t6 busy r%0d", r), 64'(bus.look_busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
